// File: rtl/rx_packet_buffer.sv
// rx_packet_buffer: packet-commit FIFO behind the USB receiver.
// Payload bytes are written speculatively while the USB CRC16 runs over them.
// A packet becomes readable only when it ends with the CRC residual and did not
// overflow. Bad, aborted or overflowing packets are rolled back. The two CRC
// bytes are stripped when a packet commits.
module rx_packet_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     packet_start,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_byte_valid,
    input  logic                     packet_end,
    input  logic                     rx_error,
    input  logic                     r_enable,
    output logic [7:0]               r_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pkt_ok,
    output logic                     pkt_bad
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUAL = 16'h800D;

    typedef enum logic {
        ST_IDLE,
        ST_RECEIVE
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     crc_reg, crc_next;
    logic [CW-1:0]   len_reg, len_next;
    logic            ovf_reg, ovf_next;
    logic [AW-1:0]   rptr_reg, rptr_next;
    logic [AW-1:0]   cptr_reg, cptr_next;
    logic [AW-1:0]   wptr_reg, wptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            full_reg, full_next;
    logic            pkt_ok_reg, pkt_ok_next;
    logic            pkt_bad_reg, pkt_bad_next;

    // Working values for the byte/EOP path of one cycle.
    logic [15:0]     crc_tmp;
    logic [AW-1:0]   wptr_tmp;
    logic [CW-1:0]   len_tmp;
    logic            ovf_tmp;
    logic [CW-1:0]   commit_len;
    logic [CW-1:0]   occ_next;
    logic            rd_fire;
    logic            mem_we;

    logic [7:0]      mem [DEPTH];

    // USB CRC16 (poly 8005), one byte folded in LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = data[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    // Next-state logic: read side, packet FSM, commit/rollback and occupancy.
    always_comb begin
        state_next   = state_reg;
        crc_next     = crc_reg;
        len_next     = len_reg;
        ovf_next     = ovf_reg;
        rptr_next    = rptr_reg;
        cptr_next    = cptr_reg;
        wptr_next    = wptr_reg;
        pkt_ok_next  = 1'b0;
        pkt_bad_next = 1'b0;
        mem_we       = 1'b0;
        commit_len   = '0;
        crc_tmp      = crc_reg;
        wptr_tmp     = wptr_reg;
        len_tmp      = len_reg;
        ovf_tmp      = ovf_reg;
        rd_fire      = r_enable && (count_reg != '0);

        if (rd_fire) begin
            rptr_next = rptr_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (packet_start) begin
                    state_next = ST_RECEIVE;
                    crc_next   = CRC_INIT;
                    len_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            ST_RECEIVE: begin
                if (rx_error || packet_start) begin
                    // Abort: drop the speculative region; a new PID restarts at once.
                    wptr_next    = cptr_reg;
                    len_next     = '0;
                    pkt_bad_next = 1'b1;
                    if (packet_start) begin
                        crc_next = CRC_INIT;
                        ovf_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (rx_byte_valid) begin
                        crc_tmp = crc16_byte(crc_reg, rx_byte);
                        if (!full_reg) begin
                            mem_we   = 1'b1;
                            wptr_tmp = wptr_reg + 1'b1;
                            if (len_reg != CW'(DEPTH)) begin
                                len_tmp = len_reg + 1'b1;
                            end
                        end else begin
                            ovf_tmp = 1'b1;
                        end
                    end
                    if (packet_end) begin
                        state_next = ST_IDLE;
                        len_next   = '0;
                        if (!ovf_tmp && (len_tmp >= CW'(2)) && (crc_tmp == CRC_RESIDUAL)) begin
                            // Commit everything except the trailing CRC bytes.
                            cptr_next   = wptr_tmp - AW'(2);
                            wptr_next   = wptr_tmp - AW'(2);
                            commit_len  = len_tmp - CW'(2);
                            pkt_ok_next = 1'b1;
                        end else begin
                            wptr_next    = cptr_reg;
                            pkt_bad_next = 1'b1;
                        end
                    end else begin
                        crc_next  = crc_tmp;
                        wptr_next = wptr_tmp;
                        len_next  = len_tmp;
                        ovf_next  = ovf_tmp;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        count_next = count_reg + commit_len - CW'(rd_fire);
        // Speculative length equals the bytes between cptr and wptr.
        occ_next   = count_next + len_next;
        full_next  = (occ_next == CW'(DEPTH));
    end

    // Control and pointer registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= ST_IDLE;
            crc_reg     <= CRC_INIT;
            len_reg     <= '0;
            ovf_reg     <= 1'b0;
            rptr_reg    <= '0;
            cptr_reg    <= '0;
            wptr_reg    <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            pkt_ok_reg  <= 1'b0;
            pkt_bad_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            crc_reg     <= crc_next;
            len_reg     <= len_next;
            ovf_reg     <= ovf_next;
            rptr_reg    <= rptr_next;
            cptr_reg    <= cptr_next;
            wptr_reg    <= wptr_next;
            count_reg   <= count_next;
            full_reg    <= full_next;
            pkt_ok_reg  <= pkt_ok_next;
            pkt_bad_reg <= pkt_bad_next;
        end
    end

    // Payload storage; cleared on reset so r_data reads 0 while empty.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[wptr_reg] <= rx_byte;
        end
    end

    assign r_data  = mem[rptr_reg];
    assign empty   = (count_reg == '0);
    assign full    = full_reg;
    assign count   = count_reg;
    assign pkt_ok  = pkt_ok_reg;
    assign pkt_bad = pkt_bad_reg;

endmodule

// File: doc/rx_packet_buffer.md
# rx_packet_buffer

Packet-commit FIFO directly downstream of `usb_receiver`. It accepts the unstuffed, NRZI-decoded payload bytes of a DATA packet, runs the USB CRC16 check over them, and exposes the payload to the encryptor read port only once the packet has ended with a good CRC. Bad, aborted or overflowing packets are rolled back and never become readable.

## Interface

Parameters:
- `DEPTH`, default 64: byte capacity. Must be a power of 2 and at least 4.

Ports:
- `clk`  in  1  system clock (one clock domain).
- `n_rst`  in  1  reset, asynchronous, active-low.
- `packet_start`  in  1  one-cycle strobe: the receiver has accepted a DATA0/DATA1 PID.
- `rx_byte`  in  8  payload byte from the receiver; LSB was received first.
- `rx_byte_valid`  in  1  one-cycle strobe qualifying `rx_byte`.
- `packet_end`  in  1  one-cycle strobe: EOP detected.
- `rx_error`  in  1  one-cycle strobe: receiver error (stuff, sync or PID). Aborts the current packet.
- `r_enable`  in  1  pop one committed byte.
- `r_data`  out  8  committed byte at the read pointer (first-word fall-through).
- `empty`  out  1  no committed bytes.
- `full`  out  1  committed plus speculative bytes equal `DEPTH`.
- `count`  out  $clog2(DEPTH)+1  number of committed bytes.
- `pkt_ok`  out  1  one-cycle pulse: packet committed.
- `pkt_bad`  out  1  one-cycle pulse: packet discarded.

## Operation

Pointers:
- `rptr`: read pointer.
- `cptr`: commit pointer.
- `wptr`: speculative write pointer.
- All three are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
- Committed region is `rptr`..`cptr`. Speculative region is `cptr`..`wptr`.
- Occupancy (committed plus speculative) is tracked with one extra bit.

FSM:
- IDLE
  - `packet_start` → RECEIVE.
  - On entry to RECEIVE: `crc` = 16'hFFFF, `len` = 0, `ovf` = 0.
- RECEIVE, on `rx_byte_valid`:
  - Fold 8 bits into `crc`, LSB first. Per bit: `fb` = bit ^ `crc[15]`; `crc` = {`crc[14:0]`, 0} ^ (`fb` ? 16'h8005 : 0).
  - If not full: write to `mem[wptr]`, `wptr`++, `len`++ (saturating).
  - If full: byte dropped, `ovf` = 1.
- RECEIVE, on `packet_end`:
  - Good packet: `ovf` = 0, `len` ≥ 2, and `crc` == 16'h800D (USB residual).
    - `cptr` = `wptr` − 2 and `wptr` = `wptr` − 2, so the two CRC bytes are stripped.
    - Pulse `pkt_ok`.
  - Otherwise: `wptr` = `cptr`, pulse `pkt_bad`.
  - Either way → IDLE.
- RECEIVE, on `rx_error`: `wptr` = `cptr`, pulse `pkt_bad`, → IDLE.
- RECEIVE, on `packet_start`: the current packet is aborted as for `rx_error` (`pkt_bad` pulses), then RECEIVE restarts fresh in the same cycle.
- Priority within one cycle:
  - `rx_error` is highest; a byte arriving in the same cycle is dropped.
  - `rx_byte_valid` is processed before `packet_end`, so a byte and EOP in the same cycle are both included.
- `rx_byte_valid`, `packet_end` and `rx_error` in IDLE are ignored; no pulses.
- Read side:
  - `r_enable` with `count` > 0: `rptr`++.
  - `r_enable` while empty: ignored, no state change.
  - Reads are independent of the FSM. A read and a commit may occur in the same cycle; `count` reflects both.
- Zero-length packet: the payload is only the CRC bytes 8'h00, 8'h00. It is good: `pkt_ok` pulses and `count` is unchanged.

## Timing

- Reset (asynchronous, takes effect immediately):
  - FSM = IDLE; all pointers = 0; `mem` cleared.
  - `r_data` = 0, `empty` = 1, `full` = 0, `count` = 0, `pkt_ok` = 0, `pkt_bad` = 0.
- Reset mid-packet discards all data, committed and speculative.
- `pkt_ok`/`pkt_bad` are registered. They assert on the clock edge that samples `packet_end`/`rx_error` and last exactly one cycle.
- Committed bytes appear in `count`, `empty` and `r_data` in that same cycle as `pkt_ok`. There is no extra latency.
- `r_data` is combinational from `mem[rptr]`. It is valid whenever `empty` = 0 and changes after the `r_enable` edge.
- `full` is registered and depends on speculative occupancy.
- Throughput: one byte write and one byte read per cycle, concurrently. Upstream delivers one byte every 64 clocks.

## Test plan

- Reset check: assert `n_rst` = 0 mid-cycle → all outputs at reset values immediately.
- Zero-length DATA0: `packet_start`, bytes 00 00, `packet_end` → `pkt_ok` = 1 for one cycle; `count` = 0; `empty` = 1.
- Good 4-byte payload 00 01 02 03 plus reference-model CRC bytes → `pkt_ok`; `count` = 4; four reads return 00, 01, 02, 03; then `empty` = 1.
- Same packet with 02 flipped to 12 → `pkt_bad`; `count` unchanged; a previously committed packet is still read intact.
- `rx_error` after 3 bytes, then a good 2-byte-payload packet → `pkt_bad`, then `pkt_ok`; `count` = 2; data equals the second packet only.
- DEPTH = 8 with 5 bytes committed, then a packet with 6 payload bytes plus CRC (overflow) → `full` asserts, `pkt_bad` pulses, `count` stays 5. Then read all 5 while a good 6-byte packet arrives, so the pointers wrap → `pkt_ok`; `count` = 6; data in order.
